// File: rtl/row_result_collector.sv
// ---------------------------------------------------------------------------
// row_result_collector
//
// Sequences a full classification over the row multiplier. For each row
// 0..NUM_ROWS-1 it pulses begin_mult with row_select = row, waits for the
// multiplier's done_row + w_result_ena strobe, saturates overflowed results
// to all-ones, stores the score in a register file and tracks the running
// argmax. At the end it reports the winning class, its score and a sticky
// overflow summary.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   start_classify    - request a classification (sampled only in IDLE)
//   begin_mult        - one-cycle pulse starting one row multiply
//   row_select        - row index, stable from ISSUE until capture
//   done_row          - multiplier row-complete strobe
//   w_result_ena      - multiplier result-valid (may linger one extra cycle)
//   row_result        - multiplier accumulated result
//   overflow          - multiplier result overflow bit
//   busy              - high in every state except IDLE
//   classify_done     - one-cycle pulse when class_out/class_score are valid
//   class_out         - index of the highest-scoring row
//   class_score       - score of class_out
//   any_overflow      - at least one row saturated in the last classification
//   score_rd_sel      - register-file read index
//   score_rd_data     - combinational register-file read (0 when out of range)
//   timeout_err       - sticky watchdog abort flag
//
// Build option:
//   ROW_COLLECTOR_WATCHDOG_EN - when defined, a 10-bit counter aborts a WAIT
//   that lasts TIMEOUT_CYCLES cycles, sets timeout_err and returns to IDLE.
//   When undefined, WAIT lasts indefinitely and timeout_err is tied 0.
// ---------------------------------------------------------------------------
module row_result_collector #(
  parameter int NUM_ROWS       = 10,
  parameter int RESULT_W       = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_classify,
  output logic                begin_mult,
  output logic [3:0]          row_select,
  input  logic                done_row,
  input  logic                w_result_ena,
  input  logic [RESULT_W-1:0] row_result,
  input  logic                overflow,
  output logic                busy,
  output logic                classify_done,
  output logic [3:0]          class_out,
  output logic [RESULT_W-1:0] class_score,
  output logic                any_overflow,
  input  logic [3:0]          score_rd_sel,
  output logic [RESULT_W-1:0] score_rd_data,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(NUM_ROWS - 1);
  localparam logic [4:0] NUM_ROWS_W = 5'(NUM_ROWS);

  state_t              r_state;
  logic [3:0]          r_idx;
  logic [3:0]          r_best_idx;
  logic [RESULT_W-1:0] r_best_score;
  logic [3:0]          r_class_out;
  logic [RESULT_W-1:0] r_class_score;
  logic                r_begin_mult;
  logic                r_busy;
  logic                r_classify_done;
  logic                r_any_overflow;
  logic [RESULT_W-1:0] r_regfile [NUM_ROWS];

`ifdef ROW_COLLECTOR_WATCHDOG_EN
  localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] r_wd_cnt;
  logic       r_timeout_err;
`endif

  logic                w_capture;
  logic [RESULT_W-1:0] w_score;
  logic                w_new_best;

  // A capture needs both strobes together; the lingering w_result_ena cycle
  // arrives with done_row low (and after we have left WAIT anyway).
  assign w_capture  = (r_state == S_WAIT) && done_row && w_result_ena;
  assign w_score    = overflow ? '1 : row_result;
  // Row 0 always seeds the argmax; strict compare keeps the lower index on ties.
  assign w_new_best = (r_idx == 4'd0) || (w_score > r_best_score);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_best_idx      <= '0;
      r_best_score    <= '0;
      r_class_out     <= '0;
      r_class_score   <= '0;
      r_begin_mult    <= 1'b0;
      r_busy          <= 1'b0;
      r_classify_done <= 1'b0;
      r_any_overflow  <= 1'b0;
`ifdef ROW_COLLECTOR_WATCHDOG_EN
      r_wd_cnt        <= '0;
      r_timeout_err   <= 1'b0;
`endif
    end else begin
      r_begin_mult    <= 1'b0;
      r_classify_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_classify) begin
            r_state        <= S_ISSUE;
            r_idx          <= '0;
            r_best_idx     <= '0;
            r_best_score   <= '0;
            r_any_overflow <= 1'b0;
            r_begin_mult   <= 1'b1;
            r_busy         <= 1'b1;
`ifdef ROW_COLLECTOR_WATCHDOG_EN
            r_timeout_err  <= 1'b0;
`endif
          end
        end

        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef ROW_COLLECTOR_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
        end

        S_WAIT: begin
          if (w_capture) begin
            r_any_overflow <= r_any_overflow | overflow;
            if (w_new_best) begin
              r_best_score <= w_score;
              r_best_idx   <= r_idx;
            end
            if (r_idx == LAST_IDX) begin
              // Results are loaded on the edge into DONE so they are valid
              // during the classify_done pulse.
              r_state         <= S_DONE;
              r_class_out     <= w_new_best ? r_idx : r_best_idx;
              r_class_score   <= w_new_best ? w_score : r_best_score;
              r_classify_done <= 1'b1;
            end else begin
              r_state      <= S_ISSUE;
              r_idx        <= r_idx + 4'd1;
              r_begin_mult <= 1'b1;
            end
          end
`ifdef ROW_COLLECTOR_WATCHDOG_EN
          else if (r_wd_cnt == WD_LIMIT) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + 10'd1;
          end
`endif
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the score register file is deliberately cleared by reset so reads
  // after reset return 0 rather than stale scores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROWS; i++) r_regfile[i] <= '0;
    end else if (w_capture) begin
      r_regfile[r_idx] <= w_score;
    end
  end

  // Read is from the registered array, so a same-cycle write is not visible.
  assign score_rd_data = ({1'b0, score_rd_sel} < NUM_ROWS_W) ? r_regfile[score_rd_sel] : '0;

  assign begin_mult    = r_begin_mult;
  assign row_select    = r_idx;
  assign busy          = r_busy;
  assign classify_done = r_classify_done;
  assign class_out     = r_class_out;
  assign class_score   = r_class_score;
  assign any_overflow  = r_any_overflow;

`ifdef ROW_COLLECTOR_WATCHDOG_EN
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_row_result_collector.sv
module tb_row_result_collector;

  localparam int NUM_ROWS = 10;
  localparam int RESULT_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_classify;
  logic                begin_mult;
  logic [3:0]          row_select;
  logic                done_row;
  logic                w_result_ena;
  logic [RESULT_W-1:0] row_result;
  logic                overflow;
  logic                busy;
  logic                classify_done;
  logic [3:0]          class_out;
  logic [RESULT_W-1:0] class_score;
  logic                any_overflow;
  logic [3:0]          score_rd_sel;
  logic [RESULT_W-1:0] score_rd_data;
  logic                timeout_err;

  row_result_collector #(
    .NUM_ROWS      (NUM_ROWS),
    .RESULT_W      (RESULT_W),
    .TIMEOUT_CYCLES(1023)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_classify(start_classify),
    .begin_mult    (begin_mult),
    .row_select    (row_select),
    .done_row      (done_row),
    .w_result_ena  (w_result_ena),
    .row_result    (row_result),
    .overflow      (overflow),
    .busy          (busy),
    .classify_done (classify_done),
    .class_out     (class_out),
    .class_score   (class_score),
    .any_overflow  (any_overflow),
    .score_rd_sel  (score_rd_sel),
    .score_rd_data (score_rd_data),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- multiplier model ----------------
  logic [31:0] scores [NUM_ROWS];
  logic        ovf    [NUM_ROWS];
  int          stall_row = -1;  // row that never completes
  int          lat       = 2;   // idle cycles between ISSUE and done
  bit          pre_ena   = 1'b0; // spurious w_result_ena (no done_row) before done

  initial begin
    int  cnt;
    int  cur;
    bit  pending;
    bit  hold;
    done_row = 1'b0; w_result_ena = 1'b0; row_result = '0; overflow = 1'b0;
    cnt = 0; cur = 0; pending = 1'b0; hold = 1'b0;
    forever begin
      @(negedge clk);
      done_row     = 1'b0;
      overflow     = 1'b0;
      w_result_ena = hold;   // valid lingers one cycle after done_row
      hold         = 1'b0;
      if (rst) begin
        pending      = 1'b0;
        w_result_ena = 1'b0;
      end else if (begin_mult) begin
        pending = 1'b1;
        cnt     = lat;
        cur     = int'(row_select);
      end else if (pending) begin
        if (cnt > 0) begin
          cnt--;
          if (pre_ena && cnt == 0) begin
            w_result_ena = 1'b1;
            row_result   = 32'hDEADBEEF;
          end
        end else if (cur != stall_row) begin
          done_row     = 1'b1;
          w_result_ena = 1'b1;
          row_result   = scores[cur];
          overflow     = ovf[cur];
          hold         = 1'b1;
          pending      = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic rd_check(input string tag, input int sel, input logic [31:0] exp);
    score_rd_sel = 4'(sel);
    #1;
    check(tag, score_rd_data, exp);
  endtask

  // Runs one classification; checks row order, begin count and one done pulse.
  // If extra_row >= 0, start_classify is pulsed again while that row is issued.
  task automatic run_classify(input string tag, input int extra_row);
    int  exp_row;
    int  n_done;
    int  cycles;
    int  post;
    bit  seen;
    exp_row = 0; n_done = 0; cycles = 0; post = 0; seen = 1'b0;
    @(negedge clk); start_classify = 1'b1;
    @(negedge clk); start_classify = 1'b0;
    while (cycles < 3000 && post < 3) begin
      if (begin_mult) begin
        check({tag, "_row_select"}, 32'(row_select), 32'(exp_row));
        exp_row++;
      end
      if (classify_done) begin
        n_done++;
        seen = 1'b1;
      end
      if (seen) post++;
      start_classify = (extra_row >= 0) && begin_mult && (int'(row_select) == extra_row);
      @(negedge clk);
      cycles++;
    end
    start_classify = 1'b0;
    check({tag, "_begin_count"}, 32'(exp_row), 32'(NUM_ROWS));
    check({tag, "_done_count"}, 32'(n_done), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; start_classify = 1'b0; score_rd_sel = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin scores[i] = '0; ovf[i] = 1'b0; end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_begin", 32'(begin_mult), 0);
    check("rst_done", 32'(classify_done), 0);
    check("rst_class_out", 32'(class_out), 0);
    check("rst_class_score", class_score, 0);
    check("rst_any_ovf", 32'(any_overflow), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_row_select", 32'(row_select), 0);
    rd_check("rst_rd0", 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: 100..1000 ascending
    for (int i = 0; i < NUM_ROWS; i++) scores[i] = 32'((i + 1) * 100);
    run_classify("basic", -1);
    check("basic_class_out", 32'(class_out), 32'd9);
    check("basic_class_score", class_score, 32'd1000);
    check("basic_any_ovf", 32'(any_overflow), 0);
    rd_check("basic_rd3", 3, 32'd400);
    rd_check("basic_rd10", 10, 32'd0);
    rd_check("basic_rd15", 15, 32'd0);
    repeat (4) @(negedge clk);
    check("basic_hold_class", 32'(class_out), 32'd9);

    // Overflow saturation on row 3
    for (int i = 0; i < NUM_ROWS; i++) scores[i] = 32'd50;
    scores[3] = 32'd5; ovf[3] = 1'b1;
    run_classify("ovf", -1);
    rd_check("ovf_rd3", 3, 32'hFFFFFFFF);
    rd_check("ovf_rd4", 4, 32'd50);
    check("ovf_class_out", 32'(class_out), 32'd3);
    check("ovf_class_score", class_score, 32'hFFFFFFFF);
    check("ovf_any_ovf", 32'(any_overflow), 32'd1);
    ovf[3] = 1'b0;

    // Tie on rows 2 and 7, with a spurious valid-only cycle before each done
    for (int i = 0; i < NUM_ROWS; i++) scores[i] = 32'd0;
    scores[2] = 32'h00001234; scores[7] = 32'h00001234;
    pre_ena = 1'b1;
    run_classify("tie", -1);
    pre_ena = 1'b0;
    check("tie_class_out", 32'(class_out), 32'd2);
    check("tie_class_score", class_score, 32'h00001234);
    check("tie_any_ovf", 32'(any_overflow), 0);
    rd_check("tie_rd7", 7, 32'h00001234);
    rd_check("tie_rd5", 5, 32'd0);

    // Descending scores at minimum multiplier latency
    lat = 0;
    for (int i = 0; i < NUM_ROWS; i++) scores[i] = 32'((NUM_ROWS - i) * 100);
    run_classify("desc", -1);
    check("desc_class_out", 32'(class_out), 32'd0);
    check("desc_class_score", class_score, 32'd1000);
    rd_check("desc_rd9", 9, 32'd100);
    lat = 2;

    // Reset while waiting on row 4
    stall_row = 4;
    @(negedge clk); start_classify = 1'b1;
    @(negedge clk); start_classify = 1'b0;
    n = 0;
    while (!(begin_mult && row_select == 4'd4) && n < 200) begin
      @(negedge clk); n++;
    end
    check("rstmid_reached_row4", 32'(n < 200), 32'd1);
    repeat (3) @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rd_check("rstmid_rd2_before", 2, 32'd800);
    rst = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_begin", 32'(begin_mult), 0);
    check("rstmid_class_out", 32'(class_out), 0);
    rd_check("rstmid_rd2", 2, 32'd0);
    rd_check("rstmid_rd0", 0, 32'd0);
    stall_row = -1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Restart with a stray start_classify during row 1
    for (int i = 0; i < NUM_ROWS; i++) scores[i] = 32'((i + 1) * 100);
    run_classify("restart", 1);
    check("restart_class_out", 32'(class_out), 32'd9);
    check("restart_class_score", class_score, 32'd1000);
    rd_check("restart_rd0", 0, 32'd100);

`ifdef ROW_COLLECTOR_WATCHDOG_EN
    // Watchdog: row 0 never completes
    begin
      int nd;
      stall_row = 0;
      @(negedge clk); start_classify = 1'b1;
      @(negedge clk); start_classify = 1'b0;
      n = 0; nd = 0;
      while (busy && n < 1100) begin
        @(negedge clk); n++;
        if (classify_done) nd++;
      end
      check("wd_cycles", 32'(n), 32'd1024);
      check("wd_timeout_err", 32'(timeout_err), 32'd1);
      check("wd_no_done", 32'(nd), 0);
      check("wd_class_kept", 32'(class_out), 32'd9);
      check("wd_score_kept", class_score, 32'd1000);
      stall_row = -1;
      repeat (3) @(negedge clk);
      check("wd_sticky", 32'(timeout_err), 32'd1);
    end
`else
    check("no_wd_timeout_err", 32'(timeout_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/row_result_collector.md
Name: row_result_collector

Overview:
- Initiator and consumer on the other side of the row-multiplier handshake.
- Drives begin_mult/row_select for rows 0..NUM_ROWS-1 in turn and captures each row_result when the multiplier signals completion.
- Saturates overflowed results, stores every score in a register file, and tracks the running argmax.
- Reports the winning class, its score, and a sticky overflow summary to the top-level controller.

Parameters:
NUM_ROWS, 10, number of rows/classes sequenced per classification (2..16)
RESULT_W, 32, width of row_result and stored scores
TIMEOUT_CYCLES, 1023, max cycles in WAIT before abort (used only with WATCHDOG_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start_classify  in  1  request a full classification; sampled only in IDLE
begin_mult  out  1  one-cycle pulse starting one row multiply
row_select  out  4  row index; stable from the ISSUE cycle until capture
done_row  in  1  multiplier row-complete strobe
w_result_ena  in  1  multiplier result-valid
row_result  in  RESULT_W  multiplier accumulated result
overflow  in  1  multiplier result overflow bit
busy  out  1  high in every state except IDLE
classify_done  out  1  one-cycle pulse when class_out/class_score are valid
class_out  out  4  index of the highest-scoring row
class_score  out  RESULT_W  score of class_out
any_overflow  out  1  at least one row saturated in the last classification
score_rd_sel  in  4  register-file read index
score_rd_data  out  RESULT_W  combinational read of stored score; 0 if score_rd_sel >= NUM_ROWS
timeout_err  out  1  sticky watchdog abort flag; tied 0 without WATCHDOG_EN

Behaviour:
- Reset (async, rst=1) clears everything:
  - State goes to IDLE.
  - begin_mult, busy, classify_done, any_overflow, timeout_err, class_out, class_score, row_select, row index, best score and all register-file entries = 0.
  - Reset mid-row abandons the row; no capture occurs.
- States and transitions:
  - IDLE: when start_classify=1, go to ISSUE. On that transition clear idx, best_idx, best_score, any_overflow, timeout_err; register-file contents are retained. start_classify in any other state is ignored.
  - ISSUE: begin_mult=1 for exactly this cycle; row_select=idx. Go to WAIT.
  - WAIT: capture when done_row=1 AND w_result_ena=1 in the same cycle. w_result_ena alone is ignored; the multiplier holds it one extra cycle and that cycle must not cause a second capture.
  - On capture:
    - score = overflow ? all-ones : row_result.
    - Write score to regfile[idx].
    - any_overflow |= overflow.
    - If idx==0 or score > best_score (unsigned, strict), set best_score=score and best_idx=idx. Ties keep the lower index.
    - If idx==NUM_ROWS-1, go to DONE; else idx+1, go to ISSUE.
  - DONE: class_out=best_idx and class_score=best_score (registered, updated this cycle); classify_done=1 for one cycle. Go to IDLE.
- Outputs and timing:
  - class_out, class_score and any_overflow hold until the next start_classify.
  - Minimum per-row latency is 1 ISSUE cycle + multiplier time + 1 capture cycle. The next begin_mult is issued the cycle after capture, when the multiplier is back in its idle state.
- Write/read collision: a regfile write and a score_rd_data read of the same index in the same cycle returns the old value.
- Widths: comparison is unsigned over RESULT_W. Saturation is all-ones of RESULT_W.

Optional Feature:
- Macro: ROW_COLLECTOR_WATCHDOG_EN.
- Defined:
  - A 10-bit counter runs in WAIT and clears on entering WAIT.
  - If it reaches TIMEOUT_CYCLES with no capture: set timeout_err=1 (sticky until next start_classify), set busy=0, go to IDLE.
  - On abort, classify_done is not pulsed and class_out/class_score keep their previous values.
- Undefined: no counter exists; timeout_err is tied 0; WAIT lasts indefinitely.

Test Plan:
- Basic classification:
  - Stimulus: model multiplier returns scores 100,200,...,1000 for rows 0..9 (no overflow).
  - Response: 10 begin_mult pulses with row_select 0..9; classify_done once; class_out=9; class_score=1000; any_overflow=0.
- Overflow saturation:
  - Stimulus: row 3 returns overflow=1, row_result=5; other rows return 50.
  - Response: score_rd_data(3)=32'hFFFFFFFF; class_out=3; any_overflow=1.
- Tie handling:
  - Stimulus: rows 2 and 7 both return 32'h00001234; others return 0.
  - Response: class_out=2.
- Double-cycle valid:
  - Stimulus: model holds w_result_ena high for 2 cycles with done_row high only in the first.
  - Response: exactly one capture per row; row_select advances by 1 per row.
- Reset and ignored start:
  - Stimulus: assert rst while WAITing on row 4.
  - Response: immediately busy=0, begin_mult=0, and regfile reads 0.
  - Stimulus: restart, then pulse start_classify during row 1.
  - Response: sequence is unaffected and classify_done pulses exactly once.
- Watchdog (ROW_COLLECTOR_WATCHDOG_EN defined):
  - Stimulus: model never asserts done_row on row 0.
  - Response: timeout_err=1 after 1023 WAIT cycles; state IDLE; no classify_done.
